// File: rtl/half_word_packer_pkg.sv
// rtl/half_word_packer_pkg.sv - state encodings and dec convention shared with the half-word selector
package half_word_packer_pkg;

  typedef enum logic [1:0] {
    PK_IDLE    = 2'd0,
    PK_GOT_LSB = 2'd1,
    PK_FULL    = 2'd2
  } pk_state_e;

  localparam logic DEC_LSB = 1'b0;
  localparam logic DEC_MSB = 1'b1;

endpackage

// File: rtl/half_word_packer.sv
// rtl/half_word_packer.sv - reassembles lsb-then-msb halves into a 2*NBITS word
// with a valid/ready output and a saturating count of out-of-order halves.
module half_word_packer
  import half_word_packer_pkg::*;
#(
  parameter int NBITS = 7,
  parameter int ERR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NBITS-1:0]   in_half,
  input  logic               in_dec,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2*NBITS-1:0] out_word,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               seq_err,
  output logic [ERR_W-1:0]   err_count
);

  pk_state_e          state;
  pk_state_e          state_next;
  logic [NBITS-1:0]   lsb_q;
  logic [NBITS-1:0]   lsb_next;
  logic [2*NBITS-1:0] word_next;
  logic               valid_next;
  logic               err_next;
  logic               accept;
  logic               drain;

  // A held word only frees the input when downstream takes it in the same cycle.
  assign in_ready = !rst && ((state != PK_FULL) || out_ready);
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PK_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    lsb_next   = lsb_q;
    word_next  = out_word;
    valid_next = out_valid;
    err_next   = 1'b0;
    case (state)
      PK_IDLE: begin
        if (accept) begin
          if (in_dec == DEC_LSB) begin
            lsb_next   = in_half;
            state_next = PK_GOT_LSB;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      PK_GOT_LSB: begin
        if (accept) begin
          if (in_dec == DEC_MSB) begin
            word_next  = {in_half, lsb_q};
            valid_next = 1'b1;
            state_next = PK_FULL;
          end else begin
            lsb_next = in_half;
            err_next = 1'b1;
          end
        end
      end
      PK_FULL: begin
        // accept can only happen here together with drain
        if (drain) begin
          valid_next = 1'b0;
          state_next = PK_IDLE;
          if (accept) begin
            if (in_dec == DEC_LSB) begin
              lsb_next   = in_half;
              state_next = PK_GOT_LSB;
            end else begin
              err_next = 1'b1;
            end
          end
        end
      end
      default: begin
        state_next = PK_IDLE;
        valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lsb_q     <= '0;
      out_word  <= '0;
      out_valid <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      lsb_q     <= lsb_next;
      out_word  <= word_next;
      out_valid <= valid_next;
      seq_err   <= err_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (err_next && (err_count != {ERR_W{1'b1}})) begin
      err_count <= err_count + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_half_word_packer.sv
// tb/tb_half_word_packer.sv - directed and random checks of half_word_packer against a queue-based model
module tb_half_word_packer;

  localparam int NBITS = 7;

  logic             clk;
  logic             rst;
  logic [NBITS-1:0] in_half;
  logic             in_dec;
  logic             in_valid;
  logic             out_ready;

  logic             in_ready, in_ready2;
  logic [13:0]      out_word, out_word2;
  logic             out_valid, out_valid2;
  logic             seq_err, seq_err2;
  logic [7:0]       err_count;
  logic [1:0]       err_count2;

  int checks = 0;
  int failures = 0;

  half_word_packer #(.NBITS(NBITS), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .in_half(in_half), .in_dec(in_dec), .in_valid(in_valid),
    .in_ready(in_ready), .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready),
    .seq_err(seq_err), .err_count(err_count)
  );

  half_word_packer #(.NBITS(NBITS), .ERR_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_half(in_half), .in_dec(in_dec), .in_valid(in_valid),
    .in_ready(in_ready2), .out_word(out_word2), .out_valid(out_valid2), .out_ready(out_ready),
    .seq_err(seq_err2), .err_count(err_count2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a pending lsb is an entry in lsbq; a held word is m_valid/m_word.
  logic [NBITS-1:0] lsbq[$];
  logic             m_valid = 1'b0;
  logic [13:0]      m_word = '0;
  logic             m_seq = 1'b0;
  int               m_n = 0;
  logic             m_ready;
  logic             live = 1'b0;

  initial begin
    logic acc, drn;
    forever begin
      @(negedge clk);
      if (live) begin
        check("out_valid", out_valid, m_valid);
        check("out_word", out_word, m_word);
        check("seq_err", seq_err, m_seq);
        check("err_count", err_count, (m_n > 255) ? 255 : m_n);
        check("sat_out_valid", out_valid2, m_valid);
        check("sat_out_word", out_word2, m_word);
        check("sat_seq_err", seq_err2, m_seq);
        check("sat_err_count", err_count2, (m_n > 3) ? 3 : m_n);
      end
      #4;
      m_ready = !rst && (!m_valid || out_ready);
      if (live || rst === 1'b1) begin
        check("in_ready", in_ready, m_ready);
        check("sat_in_ready", in_ready2, m_ready);
      end
      if (rst) begin
        lsbq.delete();
        m_valid = 1'b0;
        m_word  = '0;
        m_seq   = 1'b0;
        m_n     = 0;
        live    = 1'b1;
      end else begin
        acc   = in_valid && m_ready;
        drn   = m_valid && out_ready;
        m_seq = 1'b0;
        if (drn) m_valid = 1'b0;
        if (acc) begin
          if (in_dec == 1'b0) begin
            if (lsbq.size() != 0) m_seq = 1'b1;
            lsbq.delete();
            lsbq.push_back(in_half);
          end else if (lsbq.size() != 0) begin
            m_word  = {in_half, lsbq[0]};
            m_valid = 1'b1;
            lsbq.delete();
          end else begin
            m_seq = 1'b1;
          end
        end
        if (m_seq) m_n++;
      end
    end
  end

  task automatic drive(input logic r, input logic v, input logic d,
                       input logic [NBITS-1:0] h, input logic ordy);
    rst = r; in_valid = v; in_dec = d; in_half = h; out_ready = ordy;
  endtask

  task automatic tick;
    @(negedge clk);
    #2;
  endtask

  initial begin
    int seq_cycles;
    drive(1, 0, 0, 0, 1);
    tick; tick;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_word", out_word, 0);
    check("rst_err_count", err_count, 0);
    check("rst_in_ready", in_ready, 0);
    drive(0, 0, 0, 0, 1);
    #1 check("post_rst_in_ready", in_ready, 1);

    // basic word
    drive(0, 1, 0, 7'h15, 1); tick;
    drive(0, 1, 1, 7'h2A, 1); tick;
    check("basic_valid", out_valid, 1);
    check("basic_word", out_word, 14'h1515);
    check("model_basic_word", m_word, 14'h1515);
    drive(0, 0, 0, 0, 1); tick;
    check("basic_drained", out_valid, 0);

    // backpressure
    drive(0, 1, 0, 7'h11, 0); tick;
    drive(0, 1, 1, 7'h22, 0); tick;
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 0, 7'h33, 0);
      #1 check("bp_in_ready", in_ready, 0);
      check("bp_word", out_word, 14'h1111);
      check("bp_valid", out_valid, 1);
      tick;
    end
    drive(0, 1, 0, 7'h01, 1);
    #1 check("bp_release_ready", in_ready, 1);
    tick;
    check("bp_drained", out_valid, 0);
    drive(0, 1, 1, 7'h02, 1); tick;
    check("bp_next_word", out_word, 14'h0101);
    drive(0, 0, 0, 0, 1); tick;

    // sequence errors
    drive(1, 0, 0, 0, 1); tick;
    drive(0, 1, 1, 7'h7F, 1); tick;
    check("stray_seq_err", seq_err, 1);
    check("stray_no_valid", out_valid, 0);
    check("stray_count", err_count, 1);
    drive(0, 1, 0, 7'h03, 1); tick;
    check("lsb_ok_no_err", seq_err, 0);
    drive(0, 1, 0, 7'h04, 1); tick;
    check("dup_lsb_err", seq_err, 1);
    check("dup_lsb_count", err_count, 2);
    drive(0, 1, 1, 7'h00, 1); tick;
    check("dup_lsb_word", out_word, 14'h0004);
    check("model_dup_word", m_word, 14'h0004);

    // reset mid-word
    drive(0, 1, 0, 7'h55, 1); tick;
    drive(1, 0, 0, 0, 1); tick;
    drive(0, 1, 1, 7'h11, 1); tick;
    check("midrst_seq_err", seq_err, 1);
    check("midrst_no_valid", out_valid, 0);
    check("midrst_word", out_word, 0);
    check("midrst_count", err_count, 1);

    // saturation on the narrow counter
    drive(1, 0, 0, 0, 1); tick;
    seq_cycles = 0;
    for (int i = 1; i <= 5; i++) begin
      drive(0, 1, 1, 7'h40, 1); tick;
      if (seq_err2) seq_cycles++;
      check("sat_count_step", err_count2, (i > 3) ? 3 : i);
    end
    drive(0, 0, 0, 0, 1); tick;
    check("sat_pulses", seq_cycles, 5);
    check("sat_hold", err_count2, 3);
    check("wide_count", err_count, 5);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            NBITS'($urandom), $urandom_range(0, 9) < 7);
      tick;
    end
    drive(0, 0, 0, 0, 1); tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
